dtlb_miss_replay: RTL and testbench

Responder side of the store AGU's TLB-miss path. Captures a miss reported by the store AGU and requests a page walk. On walk completion it drives the AGU's miss-execute replay inputs (mex_en / mex_addr / mex_attr) so the AGU re-looks-up the TLB. It holds the AGU's bus_hold while a miss is outstanding, and retries or reports a fault.

---
 rtl/dtlb_miss_replay_pkg.sv | 30 +++
 rtl/dtlb_miss_replay_if.sv | 39 +++
 rtl/dtlb_miss_replay_capture.sv | 49 ++++
 rtl/dtlb_miss_replay.sv | 151 +++++++++++++++
 tb/tb_dtlb_miss_replay.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtlb_miss_replay_pkg.sv
// Shared types for the store-AGU TLB-miss replay unit: FSM states, fault codes, widths.
package dtlb_miss_replay_pkg;

  localparam int MISS_ADDR_W      = 44;
  localparam int MISS_ATTR_W      = 4;
  // Must track the AGU's TLB lookup tag width ({proc[20:0], va[43:13]}).
  localparam int AGU_TLB_IP_WIDTH = 52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_REPLAY,
    ST_CHECK,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_WALK  = 2'b01,
    FC_RETRY = 2'b10,
    FC_TMO   = 2'b11
  } fault_code_e;

  // clog2(retry_max+1), kept at least one bit so RETRY_MAX=0 still has a counter.
  function automatic int retry_cnt_w(input int retry_max);
    return (retry_max > 0) ? $clog2(retry_max + 1) : 1;
  endfunction

endpackage

// File: rtl/dtlb_miss_replay_if.sv
// AGU / page-walker side signals of the TLB-miss replay unit; slave is the replay unit.
interface dtlb_miss_replay_if #(
  parameter int TLB_IP_WIDTH = 52
);
  import dtlb_miss_replay_pkg::*;

  logic                    tlbMiss;
  logic [MISS_ADDR_W-1:0]  miss_addr;
  logic [MISS_ATTR_W-1:0]  miss_attr;
  logic [TLB_IP_WIDTH-1:0] miss_tlb_addr;
  logic                    except;
  logic                    walk_req;
  logic [TLB_IP_WIDTH-1:0] walk_addr;
  logic                    walk_ack;
  logic                    walk_done;
  logic                    walk_fault;
  logic                    mex_en;
  logic [MISS_ADDR_W-1:0]  mex_addr;
  logic [MISS_ATTR_W-1:0]  mex_attr;
  logic                    tlb_hit;
  logic                    bus_hold;
  logic                    miss_fault;
  logic [1:0]              miss_fault_code;

  modport slave (
    input  tlbMiss, miss_addr, miss_attr, miss_tlb_addr, except,
           walk_ack, walk_done, walk_fault, tlb_hit,
    output walk_req, walk_addr, mex_en, mex_addr, mex_attr,
           bus_hold, miss_fault, miss_fault_code
  );

  modport master (
    output tlbMiss, miss_addr, miss_attr, miss_tlb_addr, except,
           walk_ack, walk_done, walk_fault, tlb_hit,
    input  walk_req, walk_addr, mex_en, mex_addr, mex_attr,
           bus_hold, miss_fault, miss_fault_code
  );

endinterface

// File: rtl/dtlb_miss_replay_capture.sv
// Captured miss context (address, attributes, TLB tag) plus the saturating replay retry counter.
module dtlb_miss_capture
  import dtlb_miss_replay_pkg::*;
#(
  parameter  int RETRY_MAX    = 3,
  parameter  int TLB_IP_WIDTH = 52,
  localparam int RC_W         = retry_cnt_w(RETRY_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clr,
  input  logic                    inc,
  input  logic [MISS_ADDR_W-1:0]  addr_in,
  input  logic [MISS_ATTR_W-1:0]  attr_in,
  input  logic [TLB_IP_WIDTH-1:0] tag_in,
  output logic [MISS_ADDR_W-1:0]  cap_addr,
  output logic [MISS_ATTR_W-1:0]  cap_attr,
  output logic [TLB_IP_WIDTH-1:0] cap_tag,
  output logic [RC_W-1:0]         retry_cnt,
  output logic                    retry_exhausted
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr <= '0;
      cap_attr <= '0;
      cap_tag  <= '0;
    end else if (load) begin
      cap_addr <= addr_in;
      cap_attr <= attr_in;
      cap_tag  <= tag_in;
    end
  end

  assign retry_exhausted = (retry_cnt >= RC_W'(RETRY_MAX));

  // A fresh capture also restarts the retry budget for the new miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (load || clr) begin
      retry_cnt <= '0;
    end else if (inc && !retry_exhausted) begin
      retry_cnt <= retry_cnt + RC_W'(1);
    end
  end

endmodule

// File: rtl/dtlb_miss_replay.sv
// Store-AGU TLB-miss responder: capture miss, request walk, replay into AGU, retry or fault.
// Optional watchdog on REQ/WAIT enabled by defining DTLB_MISS_TIMEOUT_EN.
module dtlb_miss_replay
  import dtlb_miss_replay_pkg::*;
#(
  parameter int RETRY_MAX    = 3,
  parameter int TLB_IP_WIDTH = AGU_TLB_IP_WIDTH,
  parameter int TMO_W        = 10
) (
  input logic                clk,
  input logic                rst,
  dtlb_miss_replay_if.slave  bus
);

  localparam int RC_W = retry_cnt_w(RETRY_MAX);

  if (TMO_W < 2) begin : g_tmo_w_chk
    $error("dtlb_miss_replay: TMO_W must be at least 2");
  end

  state_e      state_q, state_d;
  fault_code_e fault_q, fault_d;
  logic        cap_load, cap_clr, cap_inc;
  logic        retry_exhausted;
  logic        tmo_expire;

  logic [MISS_ADDR_W-1:0]  cap_addr;
  logic [MISS_ATTR_W-1:0]  cap_attr;
  logic [TLB_IP_WIDTH-1:0] cap_tag;
  logic [RC_W-1:0]         retry_cnt;

  dtlb_miss_capture #(
    .RETRY_MAX    (RETRY_MAX),
    .TLB_IP_WIDTH (TLB_IP_WIDTH)
  ) u_capture (
    .clk             (clk),
    .rst             (rst),
    .load            (cap_load),
    .clr             (cap_clr),
    .inc             (cap_inc),
    .addr_in         (bus.miss_addr),
    .attr_in         (bus.miss_attr),
    .tag_in          (bus.miss_tlb_addr),
    .cap_addr        (cap_addr),
    .cap_attr        (cap_attr),
    .cap_tag         (cap_tag),
    .retry_cnt       (retry_cnt),
    .retry_exhausted (retry_exhausted)
  );

`ifdef DTLB_MISS_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  // Expire on the edge where the counter would reach all-ones, so REQ/WAIT last 2^TMO_W-1 cycles.
  assign tmo_expire = ((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
                      (tmo_q == {{(TMO_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (bus.except || ((state_d == ST_REQ) && (state_q != ST_REQ))) begin
      tmo_q <= '0;
    end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fault_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fault_d  = FC_NONE;
    cap_load = 1'b0;
    cap_clr  = 1'b0;
    cap_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.tlbMiss && !bus.except) begin
          state_d  = ST_REQ;
          cap_load = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.except) begin
          state_d = ST_IDLE;
        end else if (tmo_expire) begin
          state_d = ST_FAULT;
          fault_d = FC_TMO;
        end else if (bus.walk_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.except) begin
          state_d = ST_IDLE;
        end else if (tmo_expire) begin
          state_d = ST_FAULT;
          fault_d = FC_TMO;
        end else if (bus.walk_done) begin
          state_d = ST_REPLAY;
        end else if (bus.walk_fault) begin
          state_d = ST_FAULT;
          fault_d = FC_WALK;
        end
      end
      // The replay strobe is already on the bus, so a flush here only skips the check.
      ST_REPLAY: begin
        state_d = bus.except ? ST_IDLE : ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.except || bus.tlb_hit) begin
          state_d = ST_IDLE;
          cap_clr = 1'b1;
        end else if (retry_exhausted) begin
          state_d = ST_FAULT;
          fault_d = FC_RETRY;
        end else begin
          state_d = ST_REQ;
          cap_inc = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.walk_req        = (state_q == ST_REQ);
  assign bus.walk_addr       = (state_q == ST_REQ) ? cap_tag : '0;
  assign bus.mex_en          = (state_q == ST_REPLAY);
  assign bus.mex_addr        = (state_q == ST_REPLAY) ? cap_addr : '0;
  assign bus.mex_attr        = (state_q == ST_REPLAY) ? cap_attr : '0;
  assign bus.bus_hold        = (state_q != ST_IDLE);
  assign bus.miss_fault      = (state_q == ST_FAULT);
  assign bus.miss_fault_code = fault_q;

endmodule

// File: tb/tb_dtlb_miss_replay.sv
// Bench for dtlb_miss_replay: vector table, random transactions vs. a transaction-level model,
// and directed flush / async-reset / RETRY_MAX=0 / timeout (DTLB_MISS_TIMEOUT_EN) sequences.
module tb_dtlb_miss_replay;
  import dtlb_miss_replay_pkg::*;

  localparam int TW   = 52;
  localparam int RMAX = 3;

  typedef struct {
    logic [43:0]   addr;
    logic [3:0]    attr;
    logic [TW-1:0] tag;
    int            ack_dly;
    int            done_dly;
    bit            fault;
    int            misses;
    int            exp_mex;
    int            exp_walk;
    int            exp_code;
    int            exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtlb_miss_replay_if #(.TLB_IP_WIDTH(TW)) bus ();
  dtlb_miss_replay_if #(.TLB_IP_WIDTH(TW)) bus0 ();

  dtlb_miss_replay #(.RETRY_MAX(RMAX), .TLB_IP_WIDTH(TW), .TMO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dtlb_miss_replay #(.RETRY_MAX(0), .TLB_IP_WIDTH(TW), .TMO_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.tlbMiss = 1'b0; bus.except = 1'b0; bus.walk_ack = 1'b0;
    bus.walk_done = 1'b0; bus.walk_fault = 1'b0; bus.tlb_hit = 1'b0;
    bus0.tlbMiss = 1'b0; bus0.except = 1'b0; bus0.walk_ack = 1'b0;
    bus0.walk_done = 1'b0; bus0.walk_fault = 1'b0; bus0.tlb_hit = 1'b0;
    bus0.miss_addr = '0; bus0.miss_attr = '0; bus0.miss_tlb_addr = '0;
  endtask

  // Transaction-level expectation from the miss/retry rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   per_walk = v.ack_dly + v.done_dly + 4;
    if (v.fault) begin
      r.exp_mex = 0; r.exp_walk = 1; r.exp_code = 1;
      r.exp_busy = v.ack_dly + v.done_dly + 3;
    end else if (v.misses <= RMAX) begin
      r.exp_mex = v.misses + 1; r.exp_walk = v.misses + 1; r.exp_code = 0;
      r.exp_busy = (v.misses + 1) * per_walk;
    end else begin
      r.exp_mex = RMAX + 1; r.exp_walk = RMAX + 1; r.exp_code = 2;
      r.exp_busy = (RMAX + 1) * per_walk + 1;
    end
    return r;
  endfunction

  task automatic capture(input logic [43:0] a, input logic [3:0] at, input logic [TW-1:0] t);
    bus.miss_addr = a; bus.miss_attr = at; bus.miss_tlb_addr = t; bus.tlbMiss = 1'b1;
    step();
    bus.tlbMiss = 1'b0;
  endtask

  // Reactive walker/TLB responder: runs until bus_hold drops, counting what the DUT did.
  task automatic serve(input vec_t v, input string nm);
    int n_mex = 0, n_walk = 0, n_fault = 0, code = 0, busy = 0, budget = 0, aw = 0, dw = 0;
    bit acked = 0, hit_next = 0;
    while (bus.bus_hold && budget < 400) begin
      busy++;
      bus.walk_ack = 1'b0; bus.walk_done = 1'b0; bus.walk_fault = 1'b0;
      bus.tlb_hit = hit_next; hit_next = 0;
      if (bus.mex_en) begin
        n_mex++;
        chk({nm, "_mex_addr"}, 64'(bus.mex_addr), 64'(v.addr));
        chk({nm, "_mex_attr"}, 64'(bus.mex_attr), 64'(v.attr));
        hit_next = (n_mex - 1 >= v.misses);
      end
      if (bus.miss_fault) begin
        n_fault++;
        code = int'(bus.miss_fault_code);
      end
      if (bus.walk_req && !acked) begin
        if (aw == v.ack_dly) begin
          chk({nm, "_walk_addr"}, 64'(bus.walk_addr), 64'(v.tag));
          bus.walk_ack = 1'b1; acked = 1; aw = 0; dw = 0; n_walk++;
        end else aw++;
      end else if (acked) begin
        if (dw == v.done_dly) begin
          if (v.fault) bus.walk_fault = 1'b1;
          else         bus.walk_done  = 1'b1;
          acked = 0;
        end else dw++;
      end
      step();
      budget++;
    end
    clear_inputs();
    chk({nm, "_idle"},  64'(bus.bus_hold), 64'(0));
    chk({nm, "_mex"},   64'(n_mex),   64'(v.exp_mex));
    chk({nm, "_walks"}, 64'(n_walk),  64'(v.exp_walk));
    chk({nm, "_nflt"},  64'(n_fault), 64'(v.exp_code != 0 ? 1 : 0));
    chk({nm, "_code"},  64'(code),    64'(v.exp_code));
    chk({nm, "_busy"},  64'(busy),    64'(v.exp_busy));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_walk_req"}, 64'(bus.walk_req), 64'(0));
    chk({nm, "_walk_addr"}, 64'(bus.walk_addr), 64'(0));
    chk({nm, "_mex_en"}, 64'(bus.mex_en), 64'(0));
    chk({nm, "_mex_addr"}, 64'(bus.mex_addr), 64'(0));
    chk({nm, "_mex_attr"}, 64'(bus.mex_attr), 64'(0));
    chk({nm, "_bus_hold"}, 64'(bus.bus_hold), 64'(0));
    chk({nm, "_miss_fault"}, 64'(bus.miss_fault), 64'(0));
    chk({nm, "_fault_code"}, 64'(bus.miss_fault_code), 64'(0));
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   cnt;

    //        addr              attr  tag              ack done flt miss  mex walk code busy
    tbl[0] = '{44'h123_4567_89A0, 4'h3, 52'hA_BCDE_F012_3456, 2, 5, 0, 0,  1, 1, 0, 11};
    tbl[1] = '{44'h0FF_0000_1234, 4'h9, 52'h1_1111_2222_3333, 1, 3, 1, 0,  0, 1, 1, 7};
    tbl[2] = '{44'hABC_DEF0_1234, 4'hC, 52'h2_2222_4444_5555, 0, 0, 0, 15, 4, 4, 2, 17};
    tbl[3] = '{44'h000_0000_2000, 4'h1, 52'h3_0000_0000_0001, 1, 2, 0, 1,  2, 2, 0, 14};
    tbl[4] = '{44'hFFF_FFFF_FFFF, 4'hF, 52'hF_FFFF_FFFF_FFFF, 0, 0, 0, 0,  1, 1, 0, 4};
    tbl[5] = '{44'h555_AAAA_5555, 4'h5, 52'h5_A5A5_A5A5_A5A5, 0, 1, 0, 3,  4, 4, 0, 20};

    clear_inputs();
    bus.miss_addr = '0; bus.miss_attr = '0; bus.miss_tlb_addr = '0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    for (int unsigned i = 0; i < 6; i++) begin
      capture(tbl[i].addr, tbl[i].attr, tbl[i].tag);
      chk($sformatf("v%0d_hold_on_capture", i), 64'(bus.bus_hold), 64'(1));
      serve(tbl[i], $sformatf("v%0d", i));
      step();
    end

    for (int unsigned i = 0; i < 25; i++) begin
      v.addr     = 44'({$urandom(), $urandom()});
      v.attr     = 4'($urandom());
      v.tag      = 52'({$urandom(), $urandom()});
      v.ack_dly  = int'($urandom_range(0, 4));
      v.done_dly = int'($urandom_range(0, 6));
      v.fault    = ($urandom_range(0, 4) == 0);
      v.misses   = int'($urandom_range(0, 5));
      v = model(v);
      capture(v.addr, v.attr, v.tag);
      serve(v, $sformatf("r%0d", i));
      if ($urandom_range(0, 1) == 1) step();
    end

    // Flush in WAIT, stale walk_done in IDLE, then an immediate new miss.
    capture(44'h111_2222_3333, 4'h2, 52'h7_7777_7777_7777);
    bus.walk_ack = 1'b1; step(); bus.walk_ack = 1'b0;
    chk("flush_req_drop", 64'(bus.walk_req), 64'(0));
    bus.except = 1'b1; step(); bus.except = 1'b0;
    chk("flush_hold", 64'(bus.bus_hold), 64'(0));
    step();
    bus.walk_done = 1'b1; step(); bus.walk_done = 1'b0;
    chk("flush_stale_mex", 64'(bus.mex_en), 64'(0));
    chk("flush_stale_hold", 64'(bus.bus_hold), 64'(0));
    step();
    chk("flush_stale_mex2", 64'(bus.mex_en), 64'(0));
    v = '{44'h444_5555_6666, 4'h6, 52'h8_8888_8888_8888, 0, 0, 0, 0, 0, 0, 0, 0};
    v = model(v);
    capture(v.addr, v.attr, v.tag);
    chk("flush_new_hold", 64'(bus.bus_hold), 64'(1));
    serve(v, "flush_new");
    step();

    // Flush in REPLAY still emits the strobe; a miss while busy is not recaptured.
    capture(44'h0AB_CDEF_0000, 4'hA, 52'h9_0000_0000_0009);
    bus.walk_ack = 1'b1; step(); bus.walk_ack = 1'b0;
    bus.walk_done = 1'b1;
    bus.tlbMiss = 1'b1; bus.miss_addr = 44'h999_9999_9999; bus.miss_attr = 4'h7;
    step();
    bus.walk_done = 1'b0; bus.tlbMiss = 1'b0;
    chk("xrep_mex_en", 64'(bus.mex_en), 64'(1));
    chk("xrep_mex_addr", 64'(bus.mex_addr), 64'(44'h0AB_CDEF_0000));
    chk("xrep_mex_attr", 64'(bus.mex_attr), 64'(4'hA));
    bus.except = 1'b1; step(); bus.except = 1'b0;
    chk("xrep_hold", 64'(bus.bus_hold), 64'(0));
    chk("xrep_mex_off", 64'(bus.mex_en), 64'(0));
    chk("xrep_nofault", 64'(bus.miss_fault), 64'(0));
    step();

    // Asynchronous reset in the middle of REPLAY.
    capture(44'h321_0000_0123, 4'h4, 52'h4_0000_0000_0004);
    bus.walk_ack = 1'b1; step(); bus.walk_ack = 1'b0;
    bus.walk_done = 1'b1; step(); bus.walk_done = 1'b0;
    chk("arst_pre_mex", 64'(bus.mex_en), 64'(1));
    #2 rst = 1'b1;
    #1 chk_all_zero("arst");
    step();
    rst = 1'b0;
    step();
    chk("arst_after", 64'(bus.bus_hold), 64'(0));

    // RETRY_MAX=0: the first post-walk miss faults with the retry code.
    bus0.miss_addr = 44'h0DE_ADBE_EF00; bus0.miss_attr = 4'hB; bus0.tlbMiss = 1'b1;
    step(); bus0.tlbMiss = 1'b0;
    bus0.walk_ack = 1'b1; step(); bus0.walk_ack = 1'b0;
    bus0.walk_done = 1'b1; step(); bus0.walk_done = 1'b0;
    chk("r0_mex_en", 64'(bus0.mex_en), 64'(1));
    chk("r0_mex_addr", 64'(bus0.mex_addr), 64'(44'h0DE_ADBE_EF00));
    step();
    bus0.tlb_hit = 1'b0; step();
    chk("r0_fault", 64'(bus0.miss_fault), 64'(1));
    chk("r0_code", 64'(bus0.miss_fault_code), 64'(2));
    step();
    chk("r0_idle", 64'(bus0.bus_hold), 64'(0));

`ifdef DTLB_MISS_TIMEOUT_EN
    capture(44'h777_0000_0777, 4'h8, 52'h6_0000_0000_0006);
    cnt = 0;
    for (int unsigned k = 0; k < 100 && !bus.miss_fault; k++) begin
      if (bus.walk_req) cnt++;
      step();
    end
    chk("tmo_fault", 64'(bus.miss_fault), 64'(1));
    chk("tmo_code", 64'(bus.miss_fault_code), 64'(3));
    chk("tmo_req_cycles", 64'(cnt), 64'(15));
    chk("tmo_req_drop", 64'(bus.walk_req), 64'(0));
    step();
    chk("tmo_idle", 64'(bus.bus_hold), 64'(0));
`else
    cnt = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
